oneshot_scheduler: RTL

- Shares one monostable timing counter among CHANNELS trigger sources, such as the sound and score one-shots in the discrete-logic arcade recreations.
- Each channel requests a pulse with a falling edge on its TRG_N input.
- Requests are latched as pending and granted round-robin. The granted channel gets one output pulse lasting exactly its DURATION clock cycles.
- Sits between the trigger decode logic and the sound/video consumers, replacing per-channel 555 emulations.

---
 rtl/oneshot_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/oneshot_scheduler.sv
// Shared monostable timer: latches falling-edge requests from several trigger
// channels and services them round-robin, one exact-length pulse at a time.
module oneshot_scheduler #(
    parameter int unsigned  CHANNELS  = 4,
    parameter int unsigned  COUNT_W   = 16,
    parameter bit           RETRIGGER = 1'b0,
    localparam int unsigned ID_W      = $clog2(CHANNELS)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [CHANNELS-1:0]         trg_n_i,
    input  logic [CHANNELS*COUNT_W-1:0] duration_i,
    output logic [CHANNELS-1:0]         out_o,
    output logic                        busy_o,
    output logic [ID_W-1:0]             active_id_o,
    output logic [CHANNELS-1:0]         pending_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_END   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [COUNT_W-1:0]  dur_q, dur_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic                busy_q, busy_d;
    logic [CHANNELS-1:0] prev_q;
    logic                arm_q;

    logic [CHANNELS-1:0] detect;
    logic [CHANNELS-1:0] set_mask;
    logic [CHANNELS-1:0] clr_mask;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     cand;
    int unsigned         idx;

    // arm_q masks the first edge after reset so a trigger held low through reset is ignored
    assign detect = arm_q ? (prev_q & ~trg_n_i) : '0;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            idx = 32'(last_q) + off;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            cand = ID_W'(idx);
            if (!grant_vld && pend_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dur_d    = dur_q;
        last_d   = last_q;
        id_d     = id_q;
        set_mask = detect;
        clr_mask = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    clr_mask[grant_idx] = 1'b1;
                    last_d = grant_idx;
                    id_d   = grant_idx;
                    dur_d  = duration_i[32'(grant_idx)*COUNT_W +: COUNT_W];
                    cnt_d  = '0;
                    if (dur_d != '0) begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (RETRIGGER && detect[id_q]) begin
                    set_mask[id_q] = 1'b0;
                    cnt_d          = '0;
                end else if (cnt_q == dur_q - COUNT_W'(1)) begin
                    state_d = S_END;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
            end
            S_END: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A fresh edge wins over the grant clear so it stays queued
        pend_d = (pend_q & ~clr_mask) | set_mask;
        busy_d = (state_d == S_COUNT);
        out_d  = busy_d ? (CHANNELS'(1) << id_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dur_q   <= '0;
            last_q  <= ID_W'(CHANNELS - 1);
            id_q    <= '0;
            pend_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            prev_q  <= '1;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            prev_q  <= trg_n_i;
            arm_q   <= 1'b1;
        end
    end

    assign out_o       = out_q;
    assign busy_o      = busy_q;
    assign active_id_o = id_q;
    assign pending_o   = pend_q;

endmodule
